// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: round-robin, message-atomic sharing of one byte-wide UART transmitter
module uart_msg_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_BITS = 8,
  parameter int MAX_MSG_BYTES = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  output logic [DATA_BITS-1:0]         out_data,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         trunc
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_MSG_BYTES + 1);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_n;
  logic [PW-1:0] rr_ptr, pick, idx;
  logic [CW-1:0] byte_cnt;
  logic [DATA_BITS-1:0] sel_data;
  logic room, accept, sel_last, end_msg;
  always_comb begin
    pick = rr_ptr;
    idx = rr_ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[idx]) pick = idx;
    end
    room = !out_valid || out_ready;
    sel_data = req_data[rr_ptr*DATA_BITS +: DATA_BITS];
    sel_last = req_last[rr_ptr];
    accept = state == XFER && req_valid[rr_ptr] && room;
    end_msg = sel_last || byte_cnt == CW'(MAX_MSG_BYTES - 1);
    req_ready = state == XFER && room ? grant : '0;
    state_n = state == IDLE ? (|req_valid ? XFER : IDLE) : (accept && end_msg ? IDLE : XFER);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= PW'(NUM_REQ - 1);
      byte_cnt <= '0;
      grant <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      trunc <= 1'b0;
    end else begin
      trunc <= accept && end_msg && !sel_last;
      if (accept) begin
        out_valid <= 1'b1;
        out_data <= sel_data;
        out_last <= end_msg;
        byte_cnt <= byte_cnt + CW'(1);
        if (end_msg) grant <= '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == IDLE && |req_valid) begin
        grant <= NUM_REQ'(1) << pick;
        rr_ptr <= pick;
        byte_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_msg_arbiter.sv
// tb_uart_msg_arbiter: scoreboard bench for uart_msg_arbiter with directed message vectors
module tb_uart_msg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_last = '0;
  logic [15:0] req_data = '0;
  logic [1:0] req_ready, grant;
  logic [1:0] hold = '0;
  logic out_valid, out_last, trunc;
  logic out_ready = 1'b1;
  logic [7:0] out_data;
  logic [8:0] sq [2][$];
  logic [8:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int trunc_cnt = 0;
  bit mon_en = 1'b1;
  always #5 clk = ~clk;
  uart_msg_arbiter #(.NUM_REQ(2), .DATA_BITS(8), .MAX_MSG_BYTES(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .grant(grant), .trunc(trunc)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic src(input int r, input logic [7:0] d, input logic l);
    sq[r].push_back({l, d});
  endtask
  task automatic ex(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask
  task automatic msg(input int r, input logic [7:0] first, input int n, input bit lastf);
    for (int k = 0; k < n; k++) src(r, first + 8'(k), lastf && k == n - 1);
  endtask
  task automatic exmsg(input logic [7:0] first, input int n, input int last_idx);
    for (int k = 0; k < n; k++) ex(first + 8'(k), k == last_idx);
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size() == 0 && !out_valid), 32'd1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    sq[0].delete();
    sq[1].delete();
    exp_q.delete();
    hold = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin : driver
    logic [1:0] fire;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready & {2{!rst}};
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (fire[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        req_valid[i] = sq[i].size() > 0 && !hold[i];
        req_data[i*8 +: 8] = sq[i].size() > 0 ? sq[i][0][7:0] : 8'h00;
        req_last[i] = sq[i].size() > 0 && sq[i][0][8];
      end
    end
  end
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (trunc) trunc_cnt++;
      if (!rst && mon_en && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_byte: got %0h expected none", {out_last, out_data});
        end else begin
          check("out_byte", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
        end
      end
    end
  end
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin : stim
    int base;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_trunc", 32'(trunc), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    // basic three-byte message from req0
    src(0, 8'h42, 1'b0); src(0, 8'h31, 1'b0); src(0, 8'h0A, 1'b1);
    ex(8'h42, 1'b0); ex(8'h31, 1'b0); ex(8'h0A, 1'b1);
    @(negedge clk);
    check("t1_grant_t", 32'(grant), 32'd0);
    check("t1_ready_idle", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("t1_grant_t1", 32'(grant), 32'b01);
    check("t1_ready_t1", 32'(req_ready), 32'b01);
    repeat (3) @(negedge clk);
    check("t1_grant_after", 32'(grant), 32'd0);
    drain();
    // simultaneous requests after reset: req0 first, one idle cycle, then req1
    do_reset();
    @(negedge clk);
    msg(0, 8'h10, 2, 1'b1); msg(1, 8'h20, 2, 1'b1);
    exmsg(8'h10, 2, 1); exmsg(8'h20, 2, 1);
    repeat (2) @(negedge clk);
    check("t2_grant_req0", 32'(grant), 32'b01);
    repeat (2) @(negedge clk);
    check("t2_idle_gap", 32'(grant), 32'd0);
    @(negedge clk);
    check("t2_grant_req1", 32'(grant), 32'b10);
    drain();
    msg(0, 8'h30, 1, 1'b1);
    ex(8'h30, 1'b1);
    drain();
    msg(0, 8'h40, 1, 1'b1); msg(1, 8'h50, 2, 1'b1);
    exmsg(8'h50, 2, 1); ex(8'h40, 1'b1);
    repeat (2) @(negedge clk);
    check("t2_rot_req1", 32'(grant), 32'b10);
    drain();
    // output stall mid-message
    msg(0, 8'h60, 5, 1'b1);
    exmsg(8'h60, 5, 4);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_data", 32'(out_data), 32'h61);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_ready_low", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    // watchdog truncation of a 40-byte message from req1
    base = trunc_cnt;
    msg(1, 8'h80, 40, 1'b0); msg(0, 8'h11, 2, 1'b1);
    exmsg(8'h80, 32, 31); exmsg(8'h11, 2, 1); exmsg(8'hA0, 8, -1);
    drain();
    check("t4_trunc_once", 32'(trunc_cnt - base), 32'd1);
    check("t4_grant_held", 32'(grant), 32'b10);
    // reset during byte 2 of a message
    do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    msg(0, 8'hA0, 4, 1'b1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    sq[0].delete();
    sq[1].delete();
    exp_q.delete();
    msg(1, 8'hB0, 1, 1'b1); msg(0, 8'hA0, 4, 1'b1);
    exmsg(8'hA0, 4, 3); ex(8'hB0, 1'b1);
    mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("t5_first_req0", 32'(grant), 32'b01);
    drain();
    // req0 pauses mid-message while req1 waits
    msg(0, 8'hC0, 4, 1'b1); msg(1, 8'hD0, 2, 1'b1);
    exmsg(8'hC0, 4, 3); exmsg(8'hD0, 2, 1);
    repeat (2) @(negedge clk);
    check("t6_grant_req0", 32'(grant), 32'b01);
    @(negedge clk);
    hold[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t6_grant_kept", 32'(grant), 32'b01);
      check("t6_req1_blocked", 32'(req_ready[1]), 32'd0);
    end
    hold[0] = 1'b0;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
